cache_nway: RTL and testbench
=============================

// Module: cache_nway
// PURPOSE
//  Parametrised N-way set-associative, write-back, write-allocate data cache for the memory stage.
//  Sits between pip_reg_m and a multi-cycle word-wide memory reached through a req/ack handshake.
//  Hits complete in the access cycle. Misses stall the pipeline while a dirty victim is written
//  back and the line is refilled. Victim choice is invalid-way-first, else per-set round-robin.
// PARAMETERS
//  DATA_WIDTH  32  word width, fixed at 32 for byte/half lane logic
//  ADDR_WIDTH  32  byte address width
//  SETS        8   number of sets, power of two, >=2
//  WAYS        2   associativity, power of two, >=1
//  LINE_WORDS  4   words per line, power of two, >=1; OFF=log2(LINE_WORDS)+2, IDX=log2(SETS)
// PORTS
//  clk_i          in   1    clock, all state updates on rising edge
//  rst_i          in   1    synchronous active-high reset
//  MemWriteM_i    in   1    store request
//  ResultSrcM_i   in   2    2'b01 = load request
//  funct3_i       in   3    LB/LH/LW/LBU/LHU; SB/SH/SW
//  addr_i         in   32   byte address (ALUResultM)
//  data_i         in   32   store data (WriteDataM)
//  data_o         out  32   load result, extended per funct3, combinational
//  stall_o        out  1    freeze F/D/E/M/W while high
//  cache_miss_o   out  1    one-cycle pulse when a miss is detected
//  mem_req_o      out  1    memory beat request, held until ack
//  mem_we_o       out  1    1 = write beat, 0 = read beat
//  mem_addr_o     out  32   word-aligned beat address
//  mem_wdata_o    out  32   write-beat data
//  mem_rdata_i    in   32   read-beat data, valid with ack
//  mem_ack_i      in   1    beat accepted/completed this cycle
// BEHAVIOUR
//  - Reset: every valid/dirty bit = 0, RR pointers = 0, state IDLE, beat counter = 0.
//    Reset forces mem_req_o = 0, stall_o = 0, cache_miss_o = 0 and data_o = 0.
//  - Reset mid-transaction aborts the burst. The memory tolerates an abandoned request.
//  - Address split: tag = addr[31:OFF+IDX], index = addr[OFF+IDX-1:OFF], word = addr[OFF-1:2].
//  - Access = MemWriteM_i | (ResultSrcM_i == 2'b01). No access means no stall, no miss, no state change.
//  - IDLE hit, load: data_o is combinational from the hit way. LB/LH sign-extend; LBU/LHU zero-extend.
//    Lane = addr[1:0] for bytes, addr[1] for halves. Misalignment is ignored, with no trap.
//  - IDLE hit, store: byte/half/word merge into the hit word at the edge, dirty = 1, stall_o = 0.
//  - IDLE miss: stall_o = 1 combinationally and cache_miss_o = 1 for that cycle.
//    Victim = lowest-index invalid way, else rr[index].
//    Next state is WB if the victim is valid and dirty, else REFILL.
//  - WB: LINE_WORDS write beats to {victim_tag, index, beat, 2'b00}, beat 0 first.
//    Each beat holds req/we/addr/wdata stable until mem_ack_i. The counter increments on ack.
//    The last ack clears the counter and moves to REFILL.
//  - REFILL: LINE_WORDS read beats from {tag, index, beat, 2'b00}. mem_rdata_i is written into the
//    victim line on each ack. After the last ack: tag written, valid = 1, dirty = 0,
//    rr[index] = victim+1 mod WAYS (only when no invalid way was used), then IDLE.
//  - Back in IDLE the held access re-evaluates as a hit: stall drops and a store then merges,
//    so one extra cycle after the final ack.
//  - stall_o = 1 throughout WB and REFILL. cache_miss_o is not re-pulsed.
//  - Miss latency with ack tied high: clean = LINE_WORDS+1 cycles; dirty = 2*LINE_WORDS+1 cycles.
//  - mem_req_o is never asserted in IDLE. A simultaneous ack and reset are resolved by reset.
// STRUCTURE
//  - Package cache_pkg:
//    - state enum {IDLE, WB, REFILL};
//    - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
//    - RESULTSRC_LOAD = 2'b01.
//  - Sub-module cache_lane_merge (combinational): load extract/extend and store byte-lane merge.
//    It is shared by the hit path and any future write-through variant.
//  - Storage: tag/valid/dirty arrays [SETS][WAYS], data [SETS][WAYS][LINE_WORDS], rr [SETS],
//    all flops, no RAM macros.
// TESTING (SETS=8, WAYS=2, LINE_WORDS=4; memory model acks 2 cycles after req unless stated)
//  1. Cold LW 0x100, mem[0x100..0x10C] = 0x11, 0x22, 0x33, 0x44 ->
//     cache_miss_o 1 pulse, 4 read beats 0x100/104/108/10C, stall_o clears, data_o = 0x00000011.
//     Then LW 0x104 -> 0x00000022 with stall_o = 0 and no mem_req_o.
//  2. SB 0x101 data 0x000000AB after test 1 -> no mem traffic.
//     LW 0x100 = 0x0000AB11, LB 0x101 = 0xFFFFFFAB, LBU 0x101 = 0x000000AB, LH 0x100 = 0xFFFFAB11.
//  3. After test 2, LW 0x180 (fills way 1), then LW 0x200 (same set 0) ->
//     4 write beats at 0x100 with first wdata 0x0000AB11, then 4 read beats at 0x200;
//     a later LW 0x180 still hits.
//  4. rst_i asserted after the 2nd refill ack of a cold LW 0x300 -> next cycle mem_req_o = 0,
//     stall_o = 0; LW 0x100 then misses (all lines invalid).
//  5. MemWriteM_i = 0, ResultSrcM_i = 2'b00, addr 0xDEADBEEF for 10 cycles ->
//     stall_o = 0, cache_miss_o = 0, mem_req_o = 0 throughout.
//  6. mem_ack_i tied high, cold LW 0x040 -> stall_o high for exactly 5 cycles.
//     A dirty-victim miss -> stall_o high for exactly 9 cycles.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the N-way data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        REFILL = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_lane_merge.sv
// Load extract/extend and store byte-lane merge for one 32-bit word.
module cache_lane_merge
    import cache_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    // Select the addressed lane, extend for loads, overlay for stores.
    always_comb begin
        byte_val  = 8'(word >> {lane, 3'b000});
        half_val  = lane[1] ? word[31:16] : word[15:0];
        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{byte_val[7]}}, byte_val};
            F3_H:    load_data = {{16{half_val[15]}}, half_val};
            F3_BU:   load_data = {24'd0, byte_val};
            F3_HU:   load_data = {16'd0, half_val};
            default: load_data = word;
        endcase
        merged = word;
        case (funct3)
            F3_B: begin
                case (lane)
                    2'd0:    merged[7:0]   = store_data[7:0];
                    2'd1:    merged[15:8]  = store_data[7:0];
                    2'd2:    merged[23:16] = store_data[7:0];
                    default: merged[31:24] = store_data[7:0];
                endcase
            end
            F3_H: begin
                if (lane[1]) merged[31:16] = store_data[15:0];
                else         merged[15:0]  = store_data[15:0];
            end
            default: merged = store_data;
        endcase
    end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate data cache with req/ack refill.
module cache_nway
    import cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SETS       = 8,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  MemWriteM_i,
    input  logic [1:0]            ResultSrcM_i,
    input  logic [2:0]            funct3_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  stall_o,
    output logic                  cache_miss_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam int unsigned OFF    = $clog2(LINE_WORDS) + 2;
    localparam int unsigned IDX    = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_WIDTH - OFF - IDX;
    localparam int unsigned WAY_W  = clog2_min1(WAYS);
    localparam int unsigned WORD_W = clog2_min1(LINE_WORDS);
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
    logic                  valid_q [SETS][WAYS];
    logic                  dirty_q [SETS][WAYS];
    logic [DATA_WIDTH-1:0] data_q  [SETS][WAYS][LINE_WORDS];
    logic [WAY_W-1:0]      rr_q    [SETS];

    state_t            state_q, state_d;
    logic [WORD_W-1:0] beat_q, beat_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              use_inv_q, use_inv_d;

    logic              access, is_load, hit, inv_found;
    logic [TAG_W-1:0]  tag;
    logic [IDX-1:0]    idx;
    logic [WORD_W-1:0] word_idx;
    logic [WAY_W-1:0]  hit_way, inv_way, victim_sel;
    logic [31:0]       hit_word, load_data, merged;
    logic              store_en, fill_en, fill_done;

    assign is_load  = (ResultSrcM_i == RESULTSRC_LOAD);
    assign access   = MemWriteM_i | is_load;
    assign tag      = TAG_W'(addr_i >> (OFF + IDX));
    assign idx      = IDX'(addr_i >> OFF);
    assign word_idx = WORD_W'((addr_i >> 2) & ADDR_WIDTH'(LINE_WORDS - 1));

    // Tag match and lowest-index invalid way for the addressed set.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_sel = inv_found ? inv_way : rr_q[idx];
        hit_word   = data_q[idx][hit_way][word_idx];
    end

    cache_lane_merge u_lane_merge (
        .funct3     (funct3_i),
        .lane       (addr_i[1:0]),
        .word       (hit_word),
        .store_data (data_i),
        .load_data  (load_data),
        .merged     (merged)
    );

    // Next-state, memory beat and stall generation; reset forces outputs low.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        victim_d     = victim_q;
        use_inv_d    = use_inv_q;
        stall_o      = 1'b0;
        cache_miss_o = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        data_o       = '0;
        store_en     = 1'b0;
        fill_en      = 1'b0;
        fill_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (hit) begin
                        store_en = MemWriteM_i;
                        if (is_load) data_o = load_data;
                    end else begin
                        stall_o      = 1'b1;
                        cache_miss_o = 1'b1;
                        victim_d     = victim_sel;
                        use_inv_d    = inv_found;
                        beat_d       = '0;
                        state_d      = (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel])
                                       ? WB : REFILL;
                    end
                end
            end
            WB: begin
                stall_o     = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = (ADDR_WIDTH'(tag_q[idx][victim_q]) << (OFF + IDX))
                            | (ADDR_WIDTH'(idx) << OFF) | (ADDR_WIDTH'(beat_q) << 2);
                mem_wdata_o = data_q[idx][victim_q][beat_q];
                if (mem_ack_i) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = REFILL;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            REFILL: begin
                stall_o    = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = (ADDR_WIDTH'(tag) << (OFF + IDX))
                           | (ADDR_WIDTH'(idx) << OFF) | (ADDR_WIDTH'(beat_q) << 2);
                if (mem_ack_i) begin
                    fill_en = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        fill_done = 1'b1;
                        beat_d    = '0;
                        state_d   = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            stall_o      = 1'b0;
            cache_miss_o = 1'b0;
            mem_req_o    = 1'b0;
            data_o       = '0;
            store_en     = 1'b0;
            fill_en      = 1'b0;
            fill_done    = 1'b0;
        end
    end

    // FSM state, beat counter and captured victim.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            victim_q  <= '0;
            use_inv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            victim_q  <= victim_d;
            use_inv_q <= use_inv_d;
        end
    end

    // Valid/dirty bits and round-robin pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < int'(SETS); s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    valid_q[s][w] <= 1'b0;
                    dirty_q[s][w] <= 1'b0;
                end
            end
        end else begin
            if (store_en) dirty_q[idx][hit_way] <= 1'b1;
            if (fill_done) begin
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
                if (!use_inv_q) rr_q[idx] <= WAY_W'((32'(victim_q) + 1) % WAYS);
            end
        end
    end

    // Tag and data storage: store merge on hit, refill beat writes.
    always_ff @(posedge clk_i) begin
        if (store_en)  data_q[idx][hit_way][word_idx] <= merged;
        if (fill_en)   data_q[idx][victim_q][beat_q]  <= mem_rdata_i;
        if (fill_done) tag_q[idx][victim_q]           <= tag;
    end

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway with a small req/ack word memory model.
module tb_cache_nway;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write;
    logic [1:0]  result_src;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [31:0] data_out, mem_addr, mem_wdata, mem_rdata;
    logic        stall, miss, mem_req, mem_we, mem_ack;

    logic [31:0] mem [0:1023];
    logic        tie_ack;
    logic        ack_q;
    int          wait_cnt;

    logic        log_we    [$];
    logic [31:0] log_addr  [$];
    logic [31:0] log_wdata [$];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_nway dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .MemWriteM_i  (mem_write),
        .ResultSrcM_i (result_src),
        .funct3_i     (funct3),
        .addr_i       (addr),
        .data_i       (wdata),
        .data_o       (data_out),
        .stall_o      (stall),
        .cache_miss_o (miss),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .mem_ack_i    (mem_ack)
    );

    assign mem_ack   = tie_ack | ack_q;
    assign mem_rdata = mem[mem_addr[11:2]];

    // Memory model: ack two cycles after req, log and apply accepted beats.
    always @(posedge clk) begin
        if (rst || tie_ack) begin
            ack_q    <= 1'b0;
            wait_cnt <= 0;
        end else if (ack_q) begin
            ack_q    <= 1'b0;
            wait_cnt <= 0;
        end else if (mem_req) begin
            if (wait_cnt == 1) begin
                ack_q    <= 1'b1;
                wait_cnt <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
        if (!rst && mem_req && mem_ack) begin
            log_we.push_back(mem_we);
            log_addr.push_back(mem_addr);
            log_wdata.push_back(mem_wdata);
            if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        log_we.delete();
        log_addr.delete();
        log_wdata.delete();
    endtask

    // Present one access until it completes; returns stall/miss cycle counts and load data.
    task automatic run_access(input string tag, input logic we, input logic ld,
                              input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                              output int stall_cyc, output int miss_cyc, output logic [31:0] rd);
        mem_write  = we;
        result_src = ld ? 2'b01 : 2'b00;
        funct3     = f3;
        addr       = a;
        wdata      = d;
        stall_cyc  = 0;
        miss_cyc   = 0;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (miss) miss_cyc++;
            if (!stall) break;
            stall_cyc++;
            @(posedge clk);
        end
        check_eq({tag, "_done"}, 32'(stall), 32'd0);
        rd = data_out;
        @(posedge clk);
        #1;
        mem_write  = 1'b0;
        result_src = 2'b00;
    endtask

    int          sc, mc, n_ack;
    logic [31:0] rd;
    logic        bad_stall, bad_miss, bad_req;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i << 2);
        mem[32'h100 >> 2] = 32'h11;
        mem[32'h104 >> 2] = 32'h22;
        mem[32'h108 >> 2] = 32'h33;
        mem[32'h10C >> 2] = 32'h44;
        tie_ack    = 1'b0;
        rst        = 1'b1;
        mem_write  = 1'b0;
        result_src = 2'b01;
        funct3     = 3'b010;
        addr       = 32'h100;
        wdata      = 32'h0;

        // Reset forces outputs low even with a load presented.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_miss",  32'(miss), 32'd0);
        check_eq("rst_req",   32'(mem_req), 32'd0);
        check_eq("rst_data",  data_out, 32'd0);
        rst        = 1'b0;
        result_src = 2'b00;
        @(posedge clk);
        #1;

        // 1: cold load miss and refill, then a hit in the same line.
        clear_log();
        run_access("t1_lw100", 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, sc, mc, rd);
        check_eq("t1_miss_pulses", 32'(mc), 32'd1);
        check_eq("t1_stall_cycles", 32'(sc), 32'd13);
        check_eq("t1_beats", 32'(log_addr.size()), 32'd4);
        for (int b = 0; b < 4; b++) begin
            check_eq($sformatf("t1_beat%0d_addr", b), log_addr[b], 32'h100 + 32'(b * 4));
            check_eq($sformatf("t1_beat%0d_we", b), 32'(log_we[b]), 32'd0);
        end
        check_eq("t1_data", rd, 32'h11);
        clear_log();
        run_access("t1_lw104", 1'b0, 1'b1, 3'b010, 32'h104, 32'h0, sc, mc, rd);
        check_eq("t1_hit_data", rd, 32'h22);
        check_eq("t1_hit_stall", 32'(sc), 32'd0);
        check_eq("t1_hit_req", 32'(log_addr.size()), 32'd0);

        // 2: byte store hit, then extended loads.
        clear_log();
        run_access("t2_sb", 1'b1, 1'b0, 3'b000, 32'h101, 32'hAB, sc, mc, rd);
        check_eq("t2_sb_stall", 32'(sc), 32'd0);
        check_eq("t2_sb_traffic", 32'(log_addr.size()), 32'd0);
        run_access("t2_lw", 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, sc, mc, rd);
        check_eq("t2_lw", rd, 32'h0000AB11);
        run_access("t2_lb", 1'b0, 1'b1, 3'b000, 32'h101, 32'h0, sc, mc, rd);
        check_eq("t2_lb", rd, 32'hFFFFFFAB);
        run_access("t2_lbu", 1'b0, 1'b1, 3'b100, 32'h101, 32'h0, sc, mc, rd);
        check_eq("t2_lbu", rd, 32'h000000AB);
        run_access("t2_lh", 1'b0, 1'b1, 3'b001, 32'h100, 32'h0, sc, mc, rd);
        check_eq("t2_lh", rd, 32'hFFFFAB11);
        check_eq("t2_no_traffic", 32'(log_addr.size()), 32'd0);

        // 3: fill way 1, then evict dirty way 0 with write-back.
        clear_log();
        run_access("t3_lw180", 1'b0, 1'b1, 3'b010, 32'h180, 32'h0, sc, mc, rd);
        check_eq("t3_180_data", rd, 32'hA0000180);
        check_eq("t3_180_beats", 32'(log_addr.size()), 32'd4);
        clear_log();
        run_access("t3_lw200", 1'b0, 1'b1, 3'b010, 32'h200, 32'h0, sc, mc, rd);
        check_eq("t3_200_beats", 32'(log_addr.size()), 32'd8);
        for (int b = 0; b < 4; b++) begin
            check_eq($sformatf("t3_wb%0d_addr", b), log_addr[b], 32'h100 + 32'(b * 4));
            check_eq($sformatf("t3_wb%0d_we", b), 32'(log_we[b]), 32'd1);
            check_eq($sformatf("t3_rd%0d_addr", b), log_addr[b + 4], 32'h200 + 32'(b * 4));
            check_eq($sformatf("t3_rd%0d_we", b), 32'(log_we[b + 4]), 32'd0);
        end
        check_eq("t3_wb0_data", log_wdata[0], 32'h0000AB11);
        check_eq("t3_wb1_data", log_wdata[1], 32'h00000022);
        check_eq("t3_200_data", rd, 32'hA0000200);
        clear_log();
        run_access("t3_lw180b", 1'b0, 1'b1, 3'b010, 32'h180, 32'h0, sc, mc, rd);
        check_eq("t3_180_hit", 32'(mc), 32'd0);
        check_eq("t3_180_hit_data", rd, 32'hA0000180);
        check_eq("t3_180_hit_traffic", 32'(log_addr.size()), 32'd0);

        // 4: reset after the second refill ack aborts the burst.
        mem_write  = 1'b0;
        result_src = 2'b01;
        funct3     = 3'b010;
        addr       = 32'h300;
        n_ack      = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_req && mem_ack) n_ack++;
            if (n_ack == 2) break;
        end
        check_eq("t4_acks_seen", 32'(n_ack), 32'd2);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        result_src = 2'b00;
        #1;
        check_eq("t4_rst_req", 32'(mem_req), 32'd0);
        check_eq("t4_rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("t4_after_req", 32'(mem_req), 32'd0);
        check_eq("t4_after_stall", 32'(stall), 32'd0);
        clear_log();
        run_access("t4_lw100", 1'b0, 1'b1, 3'b010, 32'h100, 32'h0, sc, mc, rd);
        check_eq("t4_miss", 32'(mc), 32'd1);
        check_eq("t4_beats", 32'(log_addr.size()), 32'd4);
        check_eq("t4_data", rd, 32'h0000AB11);

        // 5: no access for ten cycles.
        mem_write  = 1'b0;
        result_src = 2'b00;
        addr       = 32'hDEADBEEF;
        bad_stall  = 1'b0;
        bad_miss   = 1'b0;
        bad_req    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bad_stall |= stall;
            bad_miss  |= miss;
            bad_req   |= mem_req;
        end
        check_eq("t5_stall", 32'(bad_stall), 32'd0);
        check_eq("t5_miss", 32'(bad_miss), 32'd0);
        check_eq("t5_req", 32'(bad_req), 32'd0);
        @(posedge clk);
        #1;

        // 6: ack tied high, clean and dirty miss latencies in set 4.
        tie_ack = 1'b1;
        run_access("t6_lw040", 1'b0, 1'b1, 3'b010, 32'h040, 32'h0, sc, mc, rd);
        check_eq("t6_clean_stall", 32'(sc), 32'd5);
        check_eq("t6_040_data", rd, 32'hA0000040);
        run_access("t6_sw040", 1'b1, 1'b0, 3'b010, 32'h040, 32'h12345678, sc, mc, rd);
        check_eq("t6_sw_stall", 32'(sc), 32'd0);
        run_access("t6_lw0c0", 1'b0, 1'b1, 3'b010, 32'h0C0, 32'h0, sc, mc, rd);
        check_eq("t6_0c0_stall", 32'(sc), 32'd5);
        check_eq("t6_0c0_data", rd, 32'hA00000C0);
        clear_log();
        run_access("t6_lw140", 1'b0, 1'b1, 3'b010, 32'h140, 32'h0, sc, mc, rd);
        check_eq("t6_dirty_stall", 32'(sc), 32'd9);
        check_eq("t6_dirty_beats", 32'(log_addr.size()), 32'd8);
        check_eq("t6_wb0_addr", log_addr[0], 32'h040);
        check_eq("t6_wb0_data", log_wdata[0], 32'h12345678);
        check_eq("t6_140_data", rd, 32'hA0000140);
        tie_ack = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
